// File: rtl/clahe_pkg.sv
// Shared sizing and state encoding for the CLAHE frame sequencer and its clear walker.
package clahe_pkg;

  localparam int TILE_NUM_BITS = 6;
  localparam int BIN_BITS      = 8;
  localparam int CNT_BITS      = TILE_NUM_BITS + BIN_BITS;
  localparam int CLEAR_WORDS   = 2 ** CNT_BITS;

  typedef enum logic [1:0] {
    ST_INIT_CLEAR = 2'd0,
    ST_ACTIVE     = 2'd1,
    ST_SWAP       = 2'd2,
    ST_RUN        = 2'd3
  } seq_state_e;

  function automatic logic is_last_word(input logic [CNT_BITS-1:0] cnt);
    return &cnt;
  endfunction

endpackage

// File: rtl/clahe_clear_walker.sv
// Walks every tile/bin word of the histogram set once per start pulse, one word per cycle.
module clahe_clear_walker
  import clahe_pkg::*;
(
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_start_pulse,
  output logic                     o_done_pulse,
  output logic [TILE_NUM_BITS-1:0] o_tile,
  output logic [BIN_BITS-1:0]      o_addr
);

  logic [CNT_BITS-1:0] r_cnt;
  logic                r_run;
  logic                r_start;
  logic                r_done;

  // Counter advances while running; done is flagged on the cycle the last word leaves the parent.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= i_start;
      r_done  <= 1'b0;
      if (i_start) begin
        r_run <= 1'b1;
        r_cnt <= '0;
      end else if (r_run) begin
        if (is_last_word(r_cnt)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  assign o_busy        = r_run;
  assign o_start_pulse = r_start;
  assign o_done_pulse  = r_done;
  assign o_tile        = r_cnt[CNT_BITS-1:BIN_BITS];
  assign o_addr        = r_cnt[BIN_BITS-1:0];

endmodule

// File: rtl/clahe_frame_seq.sv
// Frame sequencer: owns the ping-pong set select, clears the histogram set between frames,
// kicks the CDF engine and arbitrates the histogram write port.
module clahe_frame_seq
  import clahe_pkg::*;
(
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     frame_end,
  input  logic [TILE_NUM_BITS-1:0] st_wr_tile_idx,
  input  logic [BIN_BITS-1:0]      st_wr_addr,
  input  logic [15:0]              st_wr_data,
  input  logic                     st_wr_en,
  output logic [TILE_NUM_BITS-1:0] hist_wr_tile_idx,
  output logic [BIN_BITS-1:0]      hist_wr_addr,
  output logic [15:0]              hist_wr_data,
  output logic                     hist_wr_en,
  output logic                     ping_pong_flag,
  output logic                     clear_start,
  output logic                     clear_done,
  output logic                     cdf_start,
  input  logic                     cdf_done,
  output logic                     mapping_valid,
  output logic                     seq_busy,
  output logic                     overrun_err,
  output logic                     collision_err
);

  seq_state_e                 r_state;
  logic                       r_kicked;
  logic                       r_pp;
  logic                       r_cdf_start;
  logic                       r_mv;
  logic                       r_busy;
  logic                       r_ovr;
  logic                       r_col;
  logic                       r_clr_seen;
  logic                       r_cdf_seen;
  logic [TILE_NUM_BITS-1:0]   r_wr_tile;
  logic [BIN_BITS-1:0]        r_wr_addr;
  logic [15:0]                r_wr_data;
  logic                       r_wr_en;

  logic                       w_fe_accept;
  logic                       w_start;
  logic                       w_drop;
  logic                       w_clr_busy;
  logic                       w_clr_start;
  logic                       w_clr_done;
  logic                       w_clr_seen;
  logic                       w_cdf_seen;
  logic [TILE_NUM_BITS-1:0]   w_clr_tile;
  logic [BIN_BITS-1:0]        w_clr_addr;

  assign w_fe_accept = frame_end && (r_state == ST_ACTIVE);
  assign w_start     = w_fe_accept || ((r_state == ST_INIT_CLEAR) && !r_kicked);
  // The statistic engine loses the port for the whole initial clear and every frame clear walk.
  assign w_drop      = w_clr_busy || (r_state == ST_INIT_CLEAR);
  assign w_clr_seen  = r_clr_seen || w_clr_done;
  assign w_cdf_seen  = r_cdf_seen || cdf_done;

  clahe_clear_walker u_walker (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .o_busy        (w_clr_busy),
    .o_start_pulse (w_clr_start),
    .o_done_pulse  (w_clr_done),
    .o_tile        (w_clr_tile),
    .o_addr        (w_clr_addr)
  );

  // Frame FSM with set select, CDF kick, mapping-valid and sticky error flags.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state     <= ST_INIT_CLEAR;
      r_kicked    <= 1'b0;
      r_pp        <= 1'b0;
      r_cdf_start <= 1'b0;
      r_mv        <= 1'b0;
      r_busy      <= 1'b1;
      r_ovr       <= 1'b0;
      r_col       <= 1'b0;
      r_clr_seen  <= 1'b0;
      r_cdf_seen  <= 1'b0;
    end else begin
      r_cdf_start <= 1'b0;
      if (frame_end && (r_state != ST_ACTIVE)) r_ovr <= 1'b1;
      if (st_wr_en && w_drop) r_col <= 1'b1;
      if ((r_state == ST_RUN) && cdf_done) r_mv <= 1'b1;
      case (r_state)
        ST_INIT_CLEAR: begin
          r_kicked <= 1'b1;
          if (w_clr_done) begin
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (frame_end) begin
            r_state     <= ST_SWAP;
            r_pp        <= ~r_pp;
            r_cdf_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SWAP: begin
          r_state    <= ST_RUN;
          r_clr_seen <= 1'b0;
          r_cdf_seen <= 1'b0;
        end
        ST_RUN: begin
          if (w_clr_seen && w_cdf_seen) begin
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_seen <= w_clr_seen;
            r_cdf_seen <= w_cdf_seen;
          end
        end
        default: begin
          r_state <= ST_INIT_CLEAR;
        end
      endcase
    end
  end

  // Histogram port mux: clear words win, otherwise statistic writes pass with one cycle latency.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_wr_tile <= '0;
      r_wr_addr <= '0;
      r_wr_data <= 16'h0000;
      r_wr_en   <= 1'b0;
    end else if (w_clr_busy) begin
      r_wr_tile <= w_clr_tile;
      r_wr_addr <= w_clr_addr;
      r_wr_data <= 16'h0000;
      r_wr_en   <= 1'b1;
    end else if (st_wr_en && !w_drop) begin
      r_wr_tile <= st_wr_tile_idx;
      r_wr_addr <= st_wr_addr;
      r_wr_data <= st_wr_data;
      r_wr_en   <= 1'b1;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign hist_wr_tile_idx = r_wr_tile;
  assign hist_wr_addr     = r_wr_addr;
  assign hist_wr_data     = r_wr_data;
  assign hist_wr_en       = r_wr_en;
  assign ping_pong_flag   = r_pp;
  assign clear_start      = w_clr_start;
  assign clear_done       = w_clr_done;
  assign cdf_start        = r_cdf_start;
  assign mapping_valid    = r_mv;
  assign seq_busy         = r_busy;
  assign overrun_err      = r_ovr;
  assign collision_err    = r_col;

endmodule

// File: tb/tb_clahe_frame_seq.sv
// Self-checking bench for clahe_frame_seq: timestamp-based reference model plus pinned literal checks.
module tb_clahe_frame_seq;

  localparam int CW  = 16384;
  localparam int BIG = 1 << 30;
  localparam int NEG = 1 << 20;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_end = 1'b0;
  logic [5:0]  st_wr_tile_idx = 6'd0;
  logic [7:0]  st_wr_addr = 8'd0;
  logic [15:0] st_wr_data = 16'd0;
  logic        st_wr_en = 1'b0;
  logic        cdf_done = 1'b0;
  logic [5:0]  hist_wr_tile_idx;
  logic [7:0]  hist_wr_addr;
  logic [15:0] hist_wr_data;
  logic        hist_wr_en, ping_pong_flag, clear_start, clear_done, cdf_start;
  logic        mapping_valid, seq_busy, overrun_err, collision_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: everything is expressed as cycle timestamps.
  int cyc = 0;
  int cs = -NEG;
  int cdfs_t = -NEG;
  int active_from = BIG;
  bit need_init = 1'b1;
  bit in_init = 1'b1;
  bit cdf_wait = 1'b0;
  bit model_on = 1'b0;
  bit m_pp, m_mv, m_ovr, m_col;
  bit e_cs, e_cd, e_cdfs, e_busy, e_en;
  int e_tile, e_addr, e_data;

  clahe_frame_seq dut (
    .pclk             (pclk),
    .rst_n            (rst_n),
    .frame_end        (frame_end),
    .st_wr_tile_idx   (st_wr_tile_idx),
    .st_wr_addr       (st_wr_addr),
    .st_wr_data       (st_wr_data),
    .st_wr_en         (st_wr_en),
    .hist_wr_tile_idx (hist_wr_tile_idx),
    .hist_wr_addr     (hist_wr_addr),
    .hist_wr_data     (hist_wr_data),
    .hist_wr_en       (hist_wr_en),
    .ping_pong_flag   (ping_pong_flag),
    .clear_start      (clear_start),
    .clear_done       (clear_done),
    .cdf_start        (cdf_start),
    .cdf_done         (cdf_done),
    .mapping_valid    (mapping_valid),
    .seq_busy         (seq_busy),
    .overrun_err      (overrun_err),
    .collision_err    (collision_err)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle t = the period following the t-th rising edge since reset release.
  task automatic model_step();
    int  t;
    int  idx;
    bit  was_active;
    bit  clear_win;
    bit  init_state;
    if (!rst_n) begin
      cyc = 0; need_init = 1'b1; in_init = 1'b1; cdf_wait = 1'b0;
      cs = -NEG; cdfs_t = -NEG; active_from = BIG;
      m_pp = 1'b0; m_mv = 1'b0; m_ovr = 1'b0; m_col = 1'b0;
      e_cs = 1'b0; e_cd = 1'b0; e_cdfs = 1'b0; e_busy = 1'b1; e_en = 1'b0;
    end else begin
      cyc++;
      t = cyc;
      was_active = !need_init && (t - 1 >= active_from);
      if (need_init) begin
        need_init = 1'b0; in_init = 1'b1; cs = t; active_from = t + CW + 1;
      end
      if (frame_end) begin
        if (was_active) begin
          m_pp = !m_pp; cs = t; cdfs_t = t; in_init = 1'b0;
          active_from = BIG; cdf_wait = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (cdf_done && cdf_wait && (t >= cs + 2)) begin
        m_mv = 1'b1; cdf_wait = 1'b0;
        active_from = (t > cs + CW + 1) ? t : cs + CW + 1;
      end
      clear_win  = (t >= cs + 1) && (t <= cs + CW);
      init_state = in_init && (t - 1 < active_from);
      e_cs   = (t == cs);
      e_cd   = (t == cs + CW);
      e_cdfs = (t == cdfs_t);
      e_busy = (t < active_from);
      if (clear_win) begin
        idx = t - cs - 1;
        e_en = 1'b1; e_tile = idx / 256; e_addr = idx % 256; e_data = 0;
      end else if (st_wr_en && !init_state) begin
        e_en = 1'b1; e_tile = int'(st_wr_tile_idx); e_addr = int'(st_wr_addr); e_data = int'(st_wr_data);
      end else begin
        e_en = 1'b0;
      end
      if (st_wr_en && (clear_win || init_state)) m_col = 1'b1;
    end
    model_on = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge pclk);
      if (model_on) begin
        chk("clear_start", clear_start, e_cs);
        chk("clear_done", clear_done, e_cd);
        chk("cdf_start", cdf_start, e_cdfs);
        chk("seq_busy", seq_busy, e_busy);
        chk("ping_pong_flag", ping_pong_flag, m_pp);
        chk("mapping_valid", mapping_valid, m_mv);
        chk("overrun_err", overrun_err, m_ovr);
        chk("collision_err", collision_err, m_col);
        chk("hist_wr_en", hist_wr_en, e_en);
        if (e_en) begin
          chk("hist_wr_tile_idx", hist_wr_tile_idx, e_tile);
          chk("hist_wr_addr", hist_wr_addr, e_addr);
          chk("hist_wr_data", hist_wr_data, e_data);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic traffic(input int n);
    for (int i = 0; i < n; i++) begin
      st_wr_en       = ($urandom_range(0, 1) == 1);
      st_wr_tile_idx = 6'($urandom);
      st_wr_addr     = 8'($urandom);
      st_wr_data     = 16'($urandom);
      cdf_done       = ($urandom_range(0, 15) == 0);
      step();
    end
    st_wr_en = 1'b0;
    cdf_done = 1'b0;
    step();
  endtask

  task automatic pulse_fe(output int n);
    n = cyc;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  int n1, n2, n3, off;

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Initial clear of set 0
    goto(1); @(negedge pclk);
    chk("lit_init_clear_start", clear_start, 32'd1);
    chk("lit_init_pp", ping_pong_flag, 32'd0);
    goto(2); @(negedge pclk);
    chk("lit_first_word_en", hist_wr_en, 32'd1);
    chk("lit_first_word_tile", hist_wr_tile_idx, 32'd0);
    chk("lit_first_word_addr", hist_wr_addr, 32'd0);
    goto(100);
    cdf_done = 1'b1; step(); cdf_done = 1'b0;
    goto(16385); @(negedge pclk);
    chk("lit_last_word_done", clear_done, 32'd1);
    chk("lit_last_word_tile", hist_wr_tile_idx, 32'd63);
    chk("lit_last_word_addr", hist_wr_addr, 32'd255);
    chk("lit_last_word_data", hist_wr_data, 32'd0);
    goto(16386); @(negedge pclk);
    chk("lit_active_busy", seq_busy, 32'd0);
    chk("lit_active_mv", mapping_valid, 32'd0);

    // Passthrough
    step();
    st_wr_tile_idx = 6'd5; st_wr_addr = 8'h3A; st_wr_data = 16'h0102; st_wr_en = 1'b1;
    step();
    st_wr_en = 1'b0;
    @(negedge pclk);
    chk("lit_pass_en", hist_wr_en, 32'd1);
    chk("lit_pass_tile", hist_wr_tile_idx, 32'd5);
    chk("lit_pass_addr", hist_wr_addr, 32'h3A);
    chk("lit_pass_data", hist_wr_data, 32'h0102);
    traffic(200);

    // Frame 1: early cdf_done, collision and overrun inside the clear window
    pulse_fe(n1); @(negedge pclk);
    chk("lit_f1_pp", ping_pong_flag, 32'd1);
    chk("lit_f1_cdf_start", cdf_start, 32'd1);
    chk("lit_f1_clear_start", clear_start, 32'd1);
    off = $urandom_range(10, 400);
    goto(n1 + off);
    st_wr_en = 1'b1; st_wr_data = 16'hBEEF; st_wr_tile_idx = 6'd9; st_wr_addr = 8'd9;
    step(); st_wr_en = 1'b0; @(negedge pclk);
    chk("lit_coll_data", hist_wr_data, 32'd0);
    chk("lit_coll_addr", hist_wr_addr, (off - 1) % 256);
    chk("lit_coll_err", collision_err, 32'd1);
    goto(n1 + 500);
    cdf_done = 1'b1; step(); cdf_done = 1'b0; @(negedge pclk);
    chk("lit_f1_mv", mapping_valid, 32'd1);
    chk("lit_f1_busy_after_cdf", seq_busy, 32'd1);
    off = $urandom_range(600, 15000);
    goto(n1 + off);
    frame_end = 1'b1; step(); frame_end = 1'b0; @(negedge pclk);
    chk("lit_ovr_err", overrun_err, 32'd1);
    chk("lit_ovr_pp", ping_pong_flag, 32'd1);
    goto(n1 + 16385); @(negedge pclk);
    chk("lit_f1_clear_done", clear_done, 32'd1);
    chk("lit_f1_busy_at_done", seq_busy, 32'd1);
    goto(n1 + 16386); @(negedge pclk);
    chk("lit_f1_idle", seq_busy, 32'd0);
    traffic(150);

    // Frame 2: cdf_done long after the clear finished
    pulse_fe(n2); @(negedge pclk);
    chk("lit_f2_pp", ping_pong_flag, 32'd0);
    goto(n2 + 16386); @(negedge pclk);
    chk("lit_f2_busy_wait_cdf", seq_busy, 32'd1);
    goto(n2 + 20000);
    cdf_done = 1'b1; @(negedge pclk);
    chk("lit_f2_busy_before", seq_busy, 32'd1);
    step(); cdf_done = 1'b0; @(negedge pclk);
    chk("lit_f2_busy_after", seq_busy, 32'd0);
    traffic(150);

    // Frame 3: reset in the middle of RUN
    pulse_fe(n3); @(negedge pclk);
    chk("lit_f3_pp", ping_pong_flag, 32'd1);
    goto(n3 + $urandom_range(1000, 3000));
    rst_n = 1'b0; step(); rst_n = 1'b1; @(negedge pclk);
    chk("lit_rst_pp", ping_pong_flag, 32'd0);
    chk("lit_rst_ovr", overrun_err, 32'd0);
    chk("lit_rst_col", collision_err, 32'd0);
    chk("lit_rst_mv", mapping_valid, 32'd0);
    goto(1); @(negedge pclk);
    chk("lit_reinit_start", clear_start, 32'd1);
    goto(16385); @(negedge pclk);
    chk("lit_reinit_done", clear_done, 32'd1);
    goto(16386); @(negedge pclk);
    chk("lit_reinit_idle", seq_busy, 32'd0);
    traffic(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clahe_frame_seq.md
Name: clahe_frame_seq

Overview:
Frame-level sequencer for the 4-bank ping-pong histogram/mapping RAM. It owns ping_pong_flag and zeroes the histogram set before each frame by walking every tile/bin through the RAM histogram write port. It starts the CDF engine on the freshly completed set and arbitrates the histogram port between the statistic engine and its own clear walker. It sits between the pixel-timing front end, the histogram statistic block, the CDF block and clahe_ram_banked.

Parameters:
TILE_NUM_BITS, 6, tile index width (64 tiles)
BIN_BITS, 8, bin address width (256 bins)
CLEAR_WORDS, 2**(TILE_NUM_BITS+BIN_BITS) = 16384, words zeroed per clear

Ports:
pclk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_end  in  1  one-cycle pulse, last pixel of frame consumed by the statistic engine
st_wr_tile_idx  in  TILE_NUM_BITS  statistic engine write tile
st_wr_addr  in  BIN_BITS  statistic engine write bin
st_wr_data  in  16  statistic engine write data
st_wr_en  in  1  statistic engine write strobe
hist_wr_tile_idx  out  TILE_NUM_BITS  to RAM
hist_wr_addr  out  BIN_BITS  to RAM
hist_wr_data  out  16  to RAM
hist_wr_en  out  1  to RAM
ping_pong_flag  out  1  set select to RAM (0: set 0 is histogram)
clear_start  out  1  pulse, clear walk begins
clear_done  out  1  pulse, last clear word written
cdf_start  out  1  pulse to CDF engine
cdf_done  in  1  pulse from CDF engine
mapping_valid  out  1  mapping set holds a valid CDF
seq_busy  out  1  clear or CDF in progress
overrun_err  out  1  sticky: frame_end while busy
collision_err  out  1  sticky: st_wr_en dropped during clear

Behaviour:
- One clock domain. Synchronous active-low reset on pclk. All outputs are registered.
- Reset values: ping_pong_flag=0, mapping_valid=0, overrun_err=0, collision_err=0, all pulses 0, hist_wr_en=0, clear counter 0. The FSM enters INIT_CLEAR.
- FSM states: INIT_CLEAR, ACTIVE, SWAP, RUN.
- INIT_CLEAR:
  - clear_start pulses in the first cycle after reset release.
  - Set 0 is zeroed, with no CDF.
  - At clear_done the FSM goes to ACTIVE.
- ACTIVE:
  - st_wr_* pass through combinationally-registered to hist_wr_* with 1-cycle latency.
  - frame_end moves the FSM to SWAP.
- SWAP (one cycle):
  - ping_pong_flag toggles.
  - clear_start and cdf_start pulse together.
  - The FSM goes to RUN.
- RUN:
  - The clear walker and CDF run concurrently. Clear uses the histogram port; CDF uses the CDF port.
  - RUN exits to ACTIVE once both clear_done and cdf_done have been seen, tracked by two sticky flags.
  - cdf_done and clear_done may arrive in either order or in the same cycle.
- Clear walker:
  - A 14-bit counter c runs 0..CLEAR_WORDS-1, one word per cycle.
  - Outputs per cycle: hist_wr_tile_idx=c[13:8], hist_wr_addr=c[7:0], data=0, en=1.
  - Writes occupy the CLEAR_WORDS cycles after clear_start.
  - clear_done is asserted in the same cycle as the write of c=16383. The counter then wraps to 0 and stops.
- Clear latency: with frame_end in cycle N, SWAP is cycle N+1, writes occur in N+2..N+16385, and clear_done is at N+16385.
- Clear owns the port. Any st_wr_en during the INIT_CLEAR or RUN clear window is dropped and sets collision_err. Once clear_done has been seen in RUN, st_wr passes through again.
- mapping_valid rises on the first cdf_done after reset and stays 1.
- seq_busy=1 in INIT_CLEAR, SWAP and RUN.
- Ignored events (FSM unaffected):
  - frame_end in INIT_CLEAR, SWAP or RUN is ignored and sets overrun_err.
  - cdf_done outside RUN is ignored.
- Reset mid-RUN aborts both clear and CDF, returns ping_pong_flag to 0 and re-clears set 0. The CDF engine is expected to reset from the same rst_n.

Decomposition:
- Shared package clahe_pkg:
  - TILE_NUM_BITS, BIN_BITS and the CLEAR_WORDS derivation.
  - The FSM state encoding typedef (2-bit: INIT_CLEAR=0, ACTIVE=1, SWAP=2, RUN=3).
- Sub-module clahe_clear_walker: counter, start/done pulses, address outputs.
- The parent holds the FSM, the port mux and the error flags.

Test Plan:
- Reset release -> clear_start at cycle 1. 16384 writes of data 0 follow, tile 0 bin 0 first and tile 63 bin 255 last. clear_done coincides with the last write, then ACTIVE with ping_pong_flag=0 and mapping_valid=0.
- In ACTIVE, st_wr tile 5, addr 0x3A, data 0x0102 -> identical hist_wr_* one cycle later.
- frame_end at N -> ping_pong_flag=1 and cdf_start/clear_start at N+1. Return cdf_done at N+500 -> mapping_valid=1 at N+501, and seq_busy stays 1 until clear_done at N+16385.
- cdf_done at N+20000 (after clear) -> seq_busy falls one cycle after cdf_done. A second frame_end toggles ping_pong_flag back to 0.
- st_wr_en during clear -> no passthrough, and collision_err=1 sticky. frame_end during RUN -> overrun_err=1 and no extra toggle.
- rst_n low mid-RUN for 1 cycle -> flag=0, error flags cleared, and a fresh INIT_CLEAR of 16384 writes.
